clock_monitor_1mhz: RTL

CLOCK_MONITOR_1MHZ -- requirements
Module: clock_monitor_1mhz

---
 rtl/clock_monitor_1mhz_pkg.sv | 28 ++
 rtl/clock_monitor_1mhz_sync_edge_detect.sv | 22 ++
 rtl/clock_monitor_1mhz.sv | 125 ++++++++++++
 3 files changed

// File: rtl/clock_monitor_1mhz_pkg.sv
// Shared clocking package: monitor state encodings and default limits.
// Reused by every divided-clock monitor in the clocking subsystem.
package clock_monitor_1mhz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_t;

    localparam int NOMINAL_DEF    = 26;
    localparam int TOL_DEF        = 1;
    localparam int LOCK_COUNT_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic period_ok(
        input logic [CNT_W-1:0] p,
        input int               nom,
        input int               tol
    );
        return (int'(p) >= nom - tol) && (int'(p) <= nom + tol);
    endfunction

endpackage

// File: rtl/clock_monitor_1mhz_sync_edge_detect.sv
// Two-flop synchronizer plus edge flop; emits a registered
// one-cycle strobe per rising edge of the asynchronous input.
module sync_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic ASYNC,
    output logic PULSE
);

    logic [2:0] sync_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q <= '0;
            PULSE  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], ASYNC};
            PULSE  <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/clock_monitor_1mhz.sv
// Period / presence monitor for the 1 MHz divided clock,
// measured in CLK_26MHZ_IN cycles.
module clock_monitor_1mhz
    import clock_monitor_1mhz_pkg::*;
#(
    parameter int NOMINAL    = NOMINAL_DEF,
    parameter int TOL        = TOL_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             CLK_26MHZ_IN,
    input  logic             RESET,
    input  logic             CLK_1MHZ_IN,
    input  logic             CLEAR,
    output logic             EDGE_PULSE,
    output logic [CNT_W-1:0] PERIOD_OUT,
    output logic             LOCKED,
    output logic             FAULT,
    output logic [CNT_W-1:0] FAULT_COUNT
);

    mon_state_t       state_q;
    mon_state_t       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] good_cnt_q;
    logic             to_armed_q;
    logic             good_evt;
    logic             bad_evt;
    logic             to_evt;
    logic             lock_hit;
    logic             fault_evt;

    sync_edge_detect u_sync (
        .CLK   (CLK_26MHZ_IN),
        .RESET (RESET),
        .ASYNC (CLK_1MHZ_IN),
        .PULSE (EDGE_PULSE)
    );

    always_comb begin
        good_evt  = EDGE_PULSE && period_ok(cnt_q, NOMINAL, TOL);
        bad_evt   = EDGE_PULSE && !good_evt;
        to_evt    = !EDGE_PULSE && to_armed_q
                    && (cnt_q == CNT_W'(TIMEOUT));
        lock_hit  = good_evt
                    && (good_cnt_q + CNT_W'(1) == CNT_W'(LOCK_COUNT));
        fault_evt = (bad_evt || to_evt)
                    && (state_q == ST_LOCKED || state_q == ST_FAULT);
    end

    // Timeout re-arms only on an edge so a dead clock counts once.
    always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
        if (!RESET) begin
            cnt_q      <= '0;
            PERIOD_OUT <= '0;
            to_armed_q <= 1'b1;
        end else if (EDGE_PULSE) begin
            cnt_q      <= CNT_W'(1);
            PERIOD_OUT <= cnt_q;
            to_armed_q <= 1'b1;
        end else begin
            if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);
            if (to_evt)
                to_armed_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
        if (!RESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (CLEAR) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:
                    if (EDGE_PULSE)
                        state_nxt = ST_ACQUIRE;
                ST_ACQUIRE:
                    if (lock_hit)
                        state_nxt = ST_LOCKED;
                    else if (to_evt)
                        state_nxt = ST_IDLE;
                ST_LOCKED:
                    if (bad_evt || to_evt)
                        state_nxt = ST_FAULT;
                ST_FAULT:
                    state_nxt = ST_FAULT;
                default:
                    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
        if (!RESET) begin
            good_cnt_q  <= '0;
            FAULT_COUNT <= '0;
        end else begin
            if (CLEAR || state_q != ST_ACQUIRE)
                good_cnt_q <= '0;
            else if (good_evt)
                good_cnt_q <= good_cnt_q + CNT_W'(1);
            else if (bad_evt)
                good_cnt_q <= '0;

            if (CLEAR)
                FAULT_COUNT <= '0;
            else if (fault_evt && FAULT_COUNT != CNT_MAX)
                FAULT_COUNT <= FAULT_COUNT + CNT_W'(1);
        end
    end

    always_comb begin
        LOCKED = (state_q == ST_LOCKED);
        FAULT  = (state_q == ST_FAULT);
    end

endmodule
